line_window_reader: RTL and testbench
=====================================

# line_window_reader

Read-side controller for the three-row pixel line buffers feeding the 3x3 convolution stage. It counts pixels written into the buffers, decides when a full 3-row band is resident, and sweeps the buffers' shared column read address across every valid window position. It presents each window to the downstream MAC with a valid/ready handshake, and throttles the upstream pixel source so that no row is overwritten before its last window has been consumed.

## Interface

- IM_DIM, 28, image width and height in pixels (square image)
- K, 3, window size; equals the number of buffered rows
- clk_i  in  1  clock
- reset  in  1  asynchronous, active-high; clock clk_i
- frame_start_i  in  1  one-cycle pulse; arms the block for a new frame (honoured only in IDLE)
- pix_valid_i  in  1  pixel beat from source; a beat counts only when pix_ready_o=1
- pix_ready_o  out  1  line buffers may accept a pixel this cycle
- pix_we_o  out  1  = pix_valid_i & pix_ready_o; drives the buffers' data_valid
- read_address_o  out  $clog2(IM_DIM)  column address to the line buffers; window spans columns read_address_o..read_address_o+K-1
- win_valid_o  out  1  window on the buffer outputs is valid
- win_ready_i  in  1  downstream accepts the window
- win_row_o  out  $clog2(IM_DIM)  output row index of the current window
- frame_done_o  out  1  one-cycle pulse after the last window is accepted

## Operation

- Counters: wr_col (0..IM_DIM-1), rows_written (0..IM_DIM), out_col (0..IM_DIM-K), out_row (0..IM_DIM-K).
- Write side: each pix_we_o increments wr_col. At wr_col=IM_DIM-1 it wraps to 0 and rows_written increments.
- pix_ready_o = (state != IDLE && state != DONE) && (rows_written < IM_DIM) && (rows_written < out_row + K). A pixel of row out_row+K is therefore never written while row out_row is still being read.
- States:
  - IDLE: all counters held at 0; frame_start_i -> FILL.
  - FILL: wait until rows_written >= out_row + K, then -> SWEEP.
  - SWEEP: win_valid_o=1, read_address_o=out_col. A fire (win_valid_o & win_ready_i) at out_col<IM_DIM-K increments out_col. A fire at out_col=IM_DIM-K -> ROW_END.
  - ROW_END: out_col<=0. If out_row=IM_DIM-K -> DONE and pulse frame_done_o; else out_row++ -> FILL.
  - DONE: -> IDLE on the next cycle.
- Windows per row = IM_DIM-K+1. Windows per frame = (IM_DIM-K+1)^2, i.e. 676 for the defaults.
- Counter compares use widths of $clog2(IM_DIM)+1 so that out_row+K cannot overflow.
- frame_start_i outside IDLE is ignored.
- Writes and window fires in the same cycle are independent. pix_ready_o uses the registered out_row, so row advance frees the next row's writes one cycle after ROW_END.

## Timing

- Reset values: pix_ready_o=0, pix_we_o=0, read_address_o=0, win_valid_o=0, win_row_o=0, frame_done_o=0, state=IDLE.
- Reset may be asserted at any time and aborts the frame immediately; no windows or frame_done_o follow.
- pix_ready_o goes high the cycle after frame_start_i.
- All outputs are registered except pix_we_o, which is combinational from pix_valid_i.
- The buffer read path is combinational, so window data is valid in the same cycle as read_address_o.
- FILL -> SWEEP: win_valid_o rises the cycle after the K-th row of the band completes.
- While win_valid_o=1 and win_ready_i=0, read_address_o and win_row_o are held stable. win_valid_o never drops without a fire.
- Throughput: one window per cycle within a row. Each row boundary costs 2 bubble cycles (ROW_END, FILL) when the data is already resident.
- frame_done_o is high for exactly one cycle, in the ROW_END cycle following the final fire.

## Test plan

- Reset mid-SWEEP (out_row=5, out_col=10): reset pulse -> all outputs 0 and state IDLE. A new frame_start_i produces first window at row 0, column 0.
- Continuous source, win_ready_i=1, IM_DIM=28: 784 pixel beats -> 676 fires, read_address_o sequences 0..25 per row, win_row_o sequences 0..25, and exactly one frame_done_o.
- Backpressure on pixels: win_ready_i=0 throughout -> pix_ready_o drops after 84 accepted beats (3 rows). Releasing win_ready_i for 26 fires re-opens it, allowing exactly 28 more beats.
- Window stall: hold win_ready_i=0 for 7 cycles at out_col=12 -> read_address_o=12 and win_valid_o=1 stable for all 7 cycles, then 13 one cycle after ready returns.
- Simultaneous fire and write at row boundary: the last fire of row 0 in the same cycle as a pix_valid_i beat -> the beat is blocked (pix_ready_o=0). The first row-3 pixel is accepted 1 cycle after ROW_END.
- frame_start_i pulsed during SWEEP -> ignored; window counts and the final window total of 676 are unchanged.

Source files
------------

// File: rtl/line_window_reader.sv
// line_window_reader
//   Read-side controller for the three-row pixel line buffers that feed the
//   3x3 convolution stage. It counts pixels written into the buffers, waits
//   until a full K-row band is resident, then sweeps the shared column read
//   address across every window position of that band. It also throttles the
//   pixel source so that no row is overwritten while windows still need it.
//
// Ports
//   clk_i          clock
//   reset          asynchronous, active-high reset
//   frame_start_i  one-cycle pulse; starts a frame (only honoured in IDLE)
//   pix_valid_i    pixel beat offered by the source
//   pix_ready_o    line buffers may accept a pixel this cycle
//   pix_we_o       pix_valid_i & pix_ready_o; buffer write enable
//   read_address_o leftmost column of the current window
//   win_valid_o    window on the buffer outputs is valid
//   win_ready_i    downstream MAC accepts the window
//   win_row_o      output row index of the current window
//   frame_done_o   one-cycle pulse in the cycle after the final window fire
//   state_o        current FSM state (debug visibility)
//
// Handshakes: a pixel beat is transferred in every cycle where
// pix_valid_i & pix_ready_o; a window is transferred (a "fire") in every
// cycle where win_valid_o & win_ready_i. While win_valid_o is high and
// win_ready_i is low, read_address_o and win_row_o hold, and win_valid_o
// only drops after a fire.
module line_window_reader #(
    parameter int IM_DIM = 28,
    parameter int K      = 3
) (
    input  logic                      clk_i,
    input  logic                      reset,
    input  logic                      frame_start_i,
    input  logic                      pix_valid_i,
    output logic                      pix_ready_o,
    output logic                      pix_we_o,
    output logic [$clog2(IM_DIM)-1:0] read_address_o,
    output logic                      win_valid_o,
    input  logic                      win_ready_i,
    output logic [$clog2(IM_DIM)-1:0] win_row_o,
    output logic                      frame_done_o,
    output logic [2:0]                state_o
);
    localparam int AW = $clog2(IM_DIM);
    // One extra bit so that out_row + K and rows_written = IM_DIM fit.
    localparam int CW = AW + 1;
    localparam logic [AW-1:0] LAST_COL = AW'(IM_DIM - 1);
    localparam logic [AW-1:0] LAST_WIN = AW'(IM_DIM - K);
    localparam logic [CW-1:0] ROWS_ALL = CW'(IM_DIM);
    localparam logic [CW-1:0] K_W      = CW'(K);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_FILL    = 3'd1,
        S_SWEEP   = 3'd2,
        S_ROW_END = 3'd3,
        S_DONE    = 3'd4
    } state_t;

    state_t        state, state_n;
    logic [AW-1:0] wr_col, wr_col_n;
    logic [CW-1:0] rows_written, rows_n;
    logic [AW-1:0] out_col, out_col_n;
    logic [AW-1:0] out_row, out_row_n;
    logic          fire;
    logic          active_n;
    logic          pix_ready_n;
    logic          frame_done_n;

    assign pix_we_o = pix_valid_i & pix_ready_o;
    assign state_o  = state;

    // Next-state and counter updates.
    always_comb begin
        state_n   = state;
        wr_col_n  = wr_col;
        rows_n    = rows_written;
        out_col_n = out_col;
        out_row_n = out_row;
        fire      = win_valid_o & win_ready_i;

        // Write side runs independently of the window sweep.
        if (pix_we_o) begin
            if (wr_col == LAST_COL) begin
                wr_col_n = '0;
                rows_n   = rows_written + CW'(1);
            end else begin
                wr_col_n = wr_col + AW'(1);
            end
        end

        case (state)
            S_IDLE: begin
                wr_col_n  = '0;
                rows_n    = '0;
                out_col_n = '0;
                out_row_n = '0;
                if (frame_start_i) begin
                    state_n = S_FILL;
                end
            end
            S_FILL: begin
                // Uses the post-write row count so the sweep starts the cycle
                // right after the last pixel of the band is written.
                if (rows_n >= {1'b0, out_row} + K_W) begin
                    state_n = S_SWEEP;
                end
            end
            S_SWEEP: begin
                if (fire) begin
                    if (out_col == LAST_WIN) begin
                        state_n = S_ROW_END;
                    end else begin
                        out_col_n = out_col + AW'(1);
                    end
                end
            end
            S_ROW_END: begin
                out_col_n = '0;
                if (out_row == LAST_WIN) begin
                    state_n = S_DONE;
                end else begin
                    out_row_n = out_row + AW'(1);
                    state_n   = S_FILL;
                end
            end
            S_DONE: begin
                wr_col_n  = '0;
                rows_n    = '0;
                out_col_n = '0;
                out_row_n = '0;
                state_n   = S_IDLE;
            end
            default: begin
                state_n = S_IDLE;
            end
        endcase
    end

    // Registered outputs are computed from next-state values so that they
    // line up with the state they describe.
    always_comb begin
        active_n     = (state_n == S_FILL) || (state_n == S_SWEEP) ||
                       (state_n == S_ROW_END);
        // Row out_row + K would overwrite the buffer still holding out_row.
        pix_ready_n  = active_n && (rows_n < ROWS_ALL) &&
                       (rows_n < {1'b0, out_row_n} + K_W);
        frame_done_n = (state_n == S_ROW_END) && (out_row_n == LAST_WIN);
    end

    always_ff @(posedge clk_i or posedge reset) begin
        if (reset) begin
            state          <= S_IDLE;
            wr_col         <= '0;
            rows_written   <= '0;
            out_col        <= '0;
            out_row        <= '0;
            pix_ready_o    <= 1'b0;
            read_address_o <= '0;
            win_valid_o    <= 1'b0;
            win_row_o      <= '0;
            frame_done_o   <= 1'b0;
        end else begin
            state          <= state_n;
            wr_col         <= wr_col_n;
            rows_written   <= rows_n;
            out_col        <= out_col_n;
            out_row        <= out_row_n;
            pix_ready_o    <= pix_ready_n;
            read_address_o <= out_col_n;
            win_valid_o    <= (state_n == S_SWEEP);
            win_row_o      <= out_row_n;
            frame_done_o   <= frame_done_n;
        end
    end

endmodule

// File: tb/tb_line_window_reader.sv
module tb_line_window_reader;
  localparam int IM_DIM = 28;
  localparam int K = 3;
  localparam int AW = $clog2(IM_DIM);
  localparam int WPR = IM_DIM - K + 1;          // windows per row
  localparam int WPF = WPR * WPR;               // windows per frame

  // clock / reset
  logic clk_i = 1'b0;
  logic reset;
  always #5 clk_i = ~clk_i;

  logic          frame_start_i;
  logic          pix_valid_i;
  logic          pix_ready_o;
  logic          pix_we_o;
  logic [AW-1:0] read_address_o;
  logic          win_valid_o;
  logic          win_ready_i;
  logic [AW-1:0] win_row_o;
  logic          frame_done_o;
  logic [2:0]    state_o;

  line_window_reader #(.IM_DIM(IM_DIM), .K(K)) dut (
    .clk_i          (clk_i),
    .reset          (reset),
    .frame_start_i  (frame_start_i),
    .pix_valid_i    (pix_valid_i),
    .pix_ready_o    (pix_ready_o),
    .pix_we_o       (pix_we_o),
    .read_address_o (read_address_o),
    .win_valid_o    (win_valid_o),
    .win_ready_i    (win_ready_i),
    .win_row_o      (win_row_o),
    .frame_done_o   (frame_done_o),
    .state_o        (state_o)
  );

  // scoreboard counters
  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // behavioural model: frame progress expressed as beats and fires
  int m_beats;        // pixels accepted this frame
  int m_fires;        // windows accepted this frame
  int m_rel;          // rows whose windows are finished and whose buffer is released
  int since_end;      // cycles since the last row-ending fire (saturating)
  bit m_active;       // block accepting pixels / producing windows
  bit m_idle;         // a frame_start would be honoured
  bit rel_pending;
  bit last_pending;
  // observation counters
  int cyc = 0;
  int start_cyc;
  int first_valid_cyc;
  int dut_fires;
  int done_count = 0;
  int first_fire_addr;
  int first_fire_row;
  bit seen_fire;

  // compare process: every cycle, on the falling edge
  always @(negedge clk_i) begin
    int rows_w, er, ec;
    bit exp_ready, exp_valid, exp_done;
    cyc++;
    if (reset) begin
      m_active = 0; m_idle = 1; rel_pending = 0; last_pending = 0;
      since_end = 7; m_beats = 0; m_fires = 0; m_rel = 0;
    end else begin
      if (since_end < 7) since_end++;
      if (since_end == 2 && rel_pending) begin m_rel++; rel_pending = 0; end
      if (since_end == 2 && last_pending) m_active = 0;
      if (since_end == 3 && last_pending) begin m_idle = 1; last_pending = 0; end

      rows_w = m_beats / IM_DIM;
      er = m_fires / WPR;
      ec = m_fires % WPR;
      exp_ready = m_active && (rows_w < IM_DIM) && (rows_w < m_rel + K);
      exp_valid = m_active && (m_fires < WPF) && (since_end >= 3) && (rows_w >= er + K);
      exp_done  = last_pending && (since_end == 1);

      check("pix_ready", pix_ready_o, exp_ready);
      check("pix_we", pix_we_o, pix_valid_i & exp_ready);
      check("win_valid", win_valid_o, exp_valid);
      if (exp_valid) begin
        check("read_address", read_address_o, ec);
        check("win_row", win_row_o, er);
      end
      check("frame_done", frame_done_o, exp_done);

      if (frame_done_o) done_count++;
      if (win_valid_o && first_valid_cyc < 0) first_valid_cyc = cyc;
      if (win_valid_o && win_ready_i) begin
        dut_fires++;
        if (!seen_fire) begin
          seen_fire = 1; first_fire_addr = read_address_o; first_fire_row = win_row_o;
        end
      end

      if (pix_valid_i && exp_ready) m_beats++;
      if (exp_valid && win_ready_i) begin
        m_fires++;
        if (ec == WPR - 1) begin
          since_end = 0;
          if (er == WPR - 1) last_pending = 1;
          else rel_pending = 1;
        end
      end
      if (m_idle && frame_start_i) begin
        m_idle = 0; m_active = 1; m_beats = 0; m_fires = 0; m_rel = 0; since_end = 7;
        start_cyc = cyc; first_valid_cyc = -1; dut_fires = 0; seen_fire = 0;
      end
    end
  end

  // driver tasks
  task automatic tick();
    @(posedge clk_i); #1;
  endtask

  task automatic sample();
    @(negedge clk_i); #1;
  endtask

  task automatic drive_rand();
    pix_valid_i = ($urandom_range(0, 3) != 0);
    win_ready_i = ($urandom_range(0, 3) != 0);
  endtask

  task automatic start_frame();
    tick();
    frame_start_i = 1'b1;
    tick();
    frame_start_i = 1'b0;
  endtask

  task automatic wait_done(input int budget, input bit rnd);
    int d0;
    int n;
    d0 = done_count;
    n = 0;
    while (done_count == d0 && n < budget) begin
      tick();
      if (rnd) drive_rand();
      n++;
    end
    if (done_count == d0) check("done_timeout", 0, 1);
    repeat (4) tick();
    check("done_once", done_count - d0, 1);
    check("frame_fires", dut_fires, WPF);
  endtask

  task automatic wait_window(input int row, input int col, input int budget, input bit rnd);
    int n;
    n = 0;
    sample();
    while (!(win_valid_o && win_row_o == AW'(row) && read_address_o == AW'(col)) && n < budget) begin
      tick();
      if (rnd) drive_rand();
      sample();
      n++;
    end
    if (n >= budget) check("window_timeout", 0, 1);
  endtask

  initial begin
    int n;
    reset = 1'b1;
    frame_start_i = 1'b0;
    pix_valid_i = 1'b0;
    win_ready_i = 1'b0;
    repeat (3) @(posedge clk_i);
    sample();
    check("rst_pix_ready", pix_ready_o, 0);
    check("rst_pix_we", pix_we_o, 0);
    check("rst_read_address", read_address_o, 0);
    check("rst_win_valid", win_valid_o, 0);
    check("rst_win_row", win_row_o, 0);
    check("rst_frame_done", frame_done_o, 0);
    check("rst_state", state_o, 0);
    tick();
    reset = 1'b0;

    // continuous source, downstream always ready
    pix_valid_i = 1'b1;
    win_ready_i = 1'b1;
    start_frame();
    sample();
    check("ready_after_start", pix_ready_o, 1);
    wait_done(3000, 0);
    check("cont_beats", m_beats, IM_DIM * IM_DIM);
    check("cont_first_valid_lat", first_valid_cyc - start_cyc, K * IM_DIM + 1);

    // pixel backpressure: no windows consumed
    win_ready_i = 1'b0;
    start_frame();
    repeat (150) tick();
    check("bp_beats_3rows", m_beats, K * IM_DIM);
    sample();
    check("bp_ready_low", pix_ready_o, 0);
    tick();
    win_ready_i = 1'b1;
    n = 0;
    sample();
    while (m_fires < WPR && n < 200) begin
      tick();
      sample();
      n++;
    end
    check("bp_fires_row0", m_fires, WPR);
    tick();
    win_ready_i = 1'b0;
    repeat (100) tick();
    check("bp_beats_4rows", m_beats, (K + 1) * IM_DIM);
    check("bp_dut_fires", dut_fires, WPR);
    drive_rand();
    wait_done(20000, 1);

    // window stall, row boundary, ignored frame_start
    pix_valid_i = 1'b1;
    win_ready_i = 1'b1;
    start_frame();
    wait_window(0, 11, 300, 0);
    tick();
    win_ready_i = 1'b0;
    for (int i = 0; i < 7; i++) begin
      sample();
      check("stall_addr", read_address_o, 12);
      check("stall_valid", win_valid_o, 1);
    end
    tick();
    win_ready_i = 1'b1;
    sample();
    check("stall_fire_addr", read_address_o, 12);
    sample();
    check("stall_next_addr", read_address_o, 13);
    wait_window(0, WPR - 1, 100, 0);
    check("rowend_fire_ready", pix_ready_o, 0);
    check("rowend_fire_we", pix_we_o, 0);
    sample();
    check("rowend_ready", pix_ready_o, 0);
    check("rowend_valid", win_valid_o, 0);
    sample();
    check("fill_ready", pix_ready_o, 1);
    check("fill_we", pix_we_o, 1);
    wait_window(1, 4, 300, 0);
    tick();
    frame_start_i = 1'b1;
    tick();
    frame_start_i = 1'b0;
    wait_done(3000, 0);

    // random traffic, reset mid-sweep, then a clean frame
    drive_rand();
    start_frame();
    wait_window(5, 10, 20000, 1);
    tick();
    reset = 1'b1;
    sample();
    check("mid_rst_pix_ready", pix_ready_o, 0);
    check("mid_rst_win_valid", win_valid_o, 0);
    check("mid_rst_read_address", read_address_o, 0);
    check("mid_rst_win_row", win_row_o, 0);
    check("mid_rst_frame_done", frame_done_o, 0);
    check("mid_rst_state", state_o, 0);
    tick();
    reset = 1'b0;
    repeat (3) tick();
    check("mid_rst_no_done", frame_done_o, 0);
    drive_rand();
    start_frame();
    wait_done(20000, 1);
    check("restart_first_addr", first_fire_addr, 0);
    check("restart_first_row", first_fire_row, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
